// File: rtl/score_pkg.sv
// score_pkg: shared types for the score accumulator.
//   bcd_t   - one packed BCD digit (0..9)
//   score_t - default-size score (SCORE_DIGITS digits, digit 0 = ones)
//   state_t - accumulator FSM states
package score_pkg;

    localparam int         SCORE_DIGITS = 4;
    localparam logic [3:0] BCD_MAX      = 4'd9;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [SCORE_DIGITS-1:0] score_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

endpackage

// File: rtl/score_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   i_req   - request vector
//   i_ptr   - index granted last; the search starts just above it
//   o_grant - one-hot grant
//   o_idx   - granted index
//   o_valid - some request was found
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    logic [PTR_W-1:0] w_c;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_c     = '0;
        // off=NREQ lands back on the pointer itself, so it is checked last
        for (int off = 1; off <= NREQ; off++) begin
            w_c = PTR_W'((int'(i_ptr) + off) % NREQ);
            if (!o_valid && i_req[w_c]) begin
                o_valid      = 1'b1;
                o_idx        = w_c;
                o_grant[w_c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_arbiter.sv
// score_arbiter: round-robin shared game-score accumulator.
// A granted source's binary points are split into two BCD digits and added
// to the score one digit per cycle; a carry out of the top digit clamps the
// score to all 9s and sets the sticky saturated flag.
//   Clk, Reset   - clock, synchronous active-low reset
//   req/points   - per-source request and packed point values
//   ack          - registered one-cycle grant pulse per source
//   clear        - new game: zero score and saturated flag
//   busy         - addition in progress
//   score_bcd    - packed BCD score, ones digit at [3:0]
//   saturated    - sticky clamp flag
//   hiscore_bcd  - best score since Reset (only with SCORE_HISCORE_EN)
module score_arbiter
    import score_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int PTS_W  = 4,
    parameter int DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*PTS_W-1:0] points,
    output logic [NREQ-1:0]       ack,
    input  logic                  clear,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  saturated
`ifdef SCORE_HISCORE_EN
    ,
    output logic [4*DIGITS-1:0]   hiscore_bcd
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int KW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             r_state, w_state_n;
    logic [PTR_W-1:0]   r_ptr, w_ptr_n;
    bcd_t [DIGITS-1:0]  r_score, w_score_n;
    logic               r_sat, w_sat_n;
    logic [NREQ-1:0]    r_ack, w_ack_n;
    logic               r_busy, w_busy_n;
    logic [KW-1:0]      r_k, w_k_n;
    logic               r_carry, w_carry_n;
    bcd_t               r_add_lo, r_add_hi, w_add_lo_n, w_add_hi_n;
    logic               w_done;     // ADD -> IDLE on a completed addition

    logic [NREQ-1:0]    w_grant;
    logic [PTR_W-1:0]   w_idx;
    logic               w_valid;
    logic [PTS_W-1:0]   w_pts;
    bcd_t               w_addend;
    logic [4:0]         w_sum;

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_pts    = points[w_idx*PTS_W +: PTS_W];
    // Points fit in two BCD digits; everything above digit 1 adds zero
    assign w_addend = (r_k == KW'(0)) ? r_add_lo :
                      (r_k == KW'(1)) ? r_add_hi : '0;
    assign w_sum    = 5'(r_score[r_k]) + 5'(w_addend) + 5'(r_carry);

    always_comb begin
        w_state_n  = r_state;
        w_ptr_n    = r_ptr;
        w_score_n  = r_score;
        w_sat_n    = r_sat;
        w_ack_n    = '0;
        w_busy_n   = r_busy;
        w_k_n      = r_k;
        w_carry_n  = r_carry;
        w_add_lo_n = r_add_lo;
        w_add_hi_n = r_add_hi;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear) begin
                    w_score_n = '0;
                    w_sat_n   = 1'b0;
                end else if (w_valid) begin
                    w_ack_n    = w_grant;
                    w_ptr_n    = w_idx;
                    w_add_lo_n = bcd_t'(32'(w_pts) % 32'd10);
                    w_add_hi_n = bcd_t'(32'(w_pts) / 32'd10);
                    // A zero-point grant is acked but never starts an addition
                    if (w_pts != '0) begin
                        w_k_n     = '0;
                        w_carry_n = 1'b0;
                        w_busy_n  = 1'b1;
                        w_state_n = ST_ADD;
                    end
                end
            end
            ST_ADD: begin
                if (clear) begin
                    w_score_n = '0;
                    w_sat_n   = 1'b0;
                    w_busy_n  = 1'b0;
                    w_state_n = ST_IDLE;
                end else begin
                    if (w_sum > 5'd9) begin
                        w_score_n[r_k] = 4'(w_sum - 5'd10);
                        w_carry_n      = 1'b1;
                    end else begin
                        w_score_n[r_k] = 4'(w_sum);
                        w_carry_n      = 1'b0;
                    end
                    w_k_n = r_k + KW'(1);
                    if (r_k == KW'(DIGITS-1)) begin
                        // Carry out of the top digit: overflow, clamp
                        if (w_sum > 5'd9) begin
                            w_score_n = {DIGITS{BCD_MAX}};
                            w_sat_n   = 1'b1;
                        end
                        w_busy_n  = 1'b0;
                        w_state_n = ST_IDLE;
                        w_done    = 1'b1;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= PTR_W'(NREQ-1);
            r_score  <= '0;
            r_sat    <= 1'b0;
            r_ack    <= '0;
            r_busy   <= 1'b0;
            r_k      <= '0;
            r_carry  <= 1'b0;
            r_add_lo <= '0;
            r_add_hi <= '0;
        end else begin
            r_state  <= w_state_n;
            r_ptr    <= w_ptr_n;
            r_score  <= w_score_n;
            r_sat    <= w_sat_n;
            r_ack    <= w_ack_n;
            r_busy   <= w_busy_n;
            r_k      <= w_k_n;
            r_carry  <= w_carry_n;
            r_add_lo <= w_add_lo_n;
            r_add_hi <= w_add_hi_n;
        end
    end

    assign ack       = r_ack;
    assign busy      = r_busy;
    assign score_bcd = r_score;
    assign saturated = r_sat;

`ifdef SCORE_HISCORE_EN
    bcd_t [DIGITS-1:0] r_hiscore;

    // Valid BCD orders the same as its packed binary, MSD in the top bits
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_hiscore <= '0;
        end else if (w_done && (w_score_n > r_hiscore)) begin
            r_hiscore <= w_score_n;
        end
    end

    assign hiscore_bcd = r_hiscore;
`endif

endmodule

// File: doc/score_arbiter.md
Name: score_arbiter

Overview:
- Shares the single game-score accumulator among NREQ point sources (hit detectors, bonus logic, ...). Sources raise a request with a point value.
- A round-robin arbiter grants one source at a time and latches its value. A sequential BCD adder then adds it to the running score, one digit per cycle.
- Output drives the score display directly as packed BCD digits.
- Replaces fixed-priority point selection, which starves low-priority sources on simultaneous hits.

Parameters:
- NREQ, 4, number of point requesters
- PTS_W, 4, width of each binary point value (0..15)
- DIGITS, 4, BCD digits in the score (max 10^DIGITS-1)

Ports:
- Clk  in  1  system clock, all logic rising-edge
- Reset  in  1  synchronous, active-low reset
- req  in  NREQ  per-source request; held until ack seen
- points  in  NREQ*PTS_W  packed point values; source i at [i*PTS_W +: PTS_W]; stable while req[i]=1
- ack  out  NREQ  one-cycle grant/accept pulse per source
- clear  in  1  new-game pulse; zeroes score
- busy  out  1  high while an addition is in progress
- score_bcd  out  4*DIGITS  packed BCD score; digit 0 (ones) at [3:0]
- saturated  out  1  sticky; score clamped at all-9s

Behaviour:
- Reset (Reset=0 at an edge): state=IDLE, score_bcd=0, ack=0, busy=0, saturated=0, rr pointer=NREQ-1 (source 0 wins first).
- States: IDLE, ADD.
- IDLE, clear=1:
  - score_bcd<=0, saturated<=0.
  - Requests are ignored this cycle (clear has priority).
  - Stay in IDLE.
- IDLE, clear=0, any req:
  - Grant the first requesting index searching upward from rr pointer+1, wrapping modulo NREQ.
  - rr pointer<=granted index.
  - ack[granted]<=1 for exactly one cycle (registered; visible the cycle after the request is sampled).
  - Latch the addend as two BCD digits: lo=pts%10, hi=pts/10. Higher addend digits are 0.
  - If pts=0: ack is still issued, state remains IDLE, score unchanged.
  - Otherwise: digit index k<=0, carry<=0, busy<=1, go to ADD.
- ADD, cycle k:
  - s = score[k] + addend[k] + carry (5-bit).
  - If s>9: score[k]<=s-10 and carry<=1. Else score[k]<=s and carry<=0.
  - k<=k+1.
  - After k=DIGITS-1: if the final carry=1, score_bcd<=all 9s and saturated<=1. Either way, busy<=0 and return to IDLE.
- Timing and throughput:
  - Latency from request sampled to final score: 1+DIGITS cycles.
  - Throughput: one nonzero grant per 1+DIGITS cycles.
  - Intermediate digits may be observed mid-ADD; consumers sample when busy=0.
- No request is sampled in ADD. Requesters drop req the cycle after ack, so a stale req is never re-granted (requires DIGITS>=2).
- clear=1 during ADD: abort the addition, score_bcd<=0, saturated<=0, busy<=0, next state IDLE. The aborted grant was already acked and is lost (intended: new game).
- Saturated score: further additions still run; the final carry re-clamps to all 9s.
- Score digits are always valid BCD (0..9).

Optional Feature:
- Macro SCORE_HISCORE_EN.
- Defined:
  - Adds output hiscore_bcd (4*DIGITS) and a high-score register, reset to 0.
  - On every ADD->IDLE transition, if the new score > hiscore (BCD magnitude compare, MSD first), hiscore<=score.
  - clear does NOT reset hiscore; only Reset does.
- Not defined: port and register absent; all other behaviour identical.

Decomposition:
- Shared package score_pkg:
  - typedef bcd_t (4-bit digit).
  - typedef score_t (DIGITS x bcd_t).
  - localparams for the state enum (IDLE, ADD) and BCD_MAX=4'd9.
- One natural sub-module, rr_arbiter: combinational round-robin pick (req, pointer -> one-hot grant, valid). Instantiated once; the pointer register lives in score_arbiter.

Test Plan:
- Single request: reset; req[0]=1, points0=7 -> ack[0] pulse 1 cycle; busy high 4 cycles; score_bcd=16'h0007.
- Carry ripple: score 0095; req[2] with points2=15 -> score_bcd=16'h0110, saturated=0.
- Fairness: req=4'b1111, all points=1, each source drops req after its ack -> ack order 0,1,2,3, final score 0004. Then rerun with sources 0 and 3 held continuously -> grants alternate 0,3,0,3.
- Saturation and zero points:
  - Score 9995; add 9 -> score_bcd=16'h9999, saturated=1. Then add 1 -> stays 9999.
  - points=0 request -> ack issued, busy stays 0, score unchanged.
- Clear and reset mid-operation:
  - Score 0500; grant points=8, then clear=1 on the second ADD cycle -> score_bcd=0, busy=0, IDLE next cycle.
  - Reset=0 mid-ADD -> all outputs at reset values next cycle.
- SCORE_HISCORE_EN: score reaches 0042; clear; score reaches 0030 -> hiscore_bcd=16'h0042. Reach 0050 -> hiscore_bcd=16'h0050.
